seq_divider: RTL

- Multi-cycle radix-2 restoring integer divider for the RISC-V CPU datapath; serves DIV/DIVU/REM/REMU.
- Forms the iterative, inverse-operation counterpart to the single-cycle add/sub unit: one trial subtraction per clock, with the carry/borrow deciding each quotient bit.
- Sits beside the ALU behind valid/ready handshakes on both the request and result sides.

---
 rtl/seq_divider.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider for DIV/DIVU/REM/REMU.
// One trial subtraction per clock on operand magnitudes. Signs are applied on the final iteration.
// Divide-by-zero and signed overflow are resolved when the request is accepted.
module seq_divider #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int unsigned RW = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [RW-1:0]      rem_q, rem_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;
    logic               ovf_q, ovf_d;

    // Datapath helpers for one restoring step and for operand conditioning
    logic [RW:0]        shifted;
    logic [RW:0]        trial;
    logic               borrow;
    logic [RW-1:0]      rem_next;
    logic [WIDTH-1:0]   q_next;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   most_neg;

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            cnt_q       <= '0;
            neg_q_q     <= 1'b0;
            neg_r_q     <= 1'b0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            q_q         <= q_d;
            dvs_q       <= dvs_d;
            cnt_q       <= cnt_d;
            neg_q_q     <= neg_q_d;
            neg_r_q     <= neg_r_d;
            out_valid_q <= out_valid_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state, iteration step and result formation
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        q_d         = q_q;
        dvs_d       = dvs_q;
        cnt_d       = cnt_q;
        neg_q_d     = neg_q_q;
        neg_r_d     = neg_r_q;
        out_valid_d = out_valid_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        ovf_d       = ovf_q;

        // Shift {rem, q} left, then subtract; the borrow decides the quotient bit
        shifted  = {rem_q, q_q[WIDTH-1]};
        trial    = shifted - {2'b00, dvs_q};
        borrow   = trial[RW];
        rem_next = borrow ? shifted[RW-1:0] : trial[RW-1:0];
        q_next   = {q_q[WIDTH-2:0], ~borrow};

        a_neg    = is_signed & dividend[WIDTH-1];
        b_neg    = is_signed & divisor[WIDTH-1];
        a_mag    = a_neg ? (~dividend + WIDTH'(1)) : dividend;
        b_mag    = b_neg ? (~divisor + WIDTH'(1)) : divisor;
        most_neg = {1'b1, {(WIDTH-1){1'b0}}};

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else if (is_signed && dividend == most_neg && divisor == '1) begin
                        quotient_d  = dividend;
                        remainder_d = '0;
                        dbz_d       = 1'b0;
                        ovf_d       = 1'b1;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        rem_d   = '0;
                        q_d     = a_mag;
                        dvs_d   = b_mag;
                        neg_q_d = a_neg ^ b_neg;
                        neg_r_d = a_neg;
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = rem_next;
                q_d   = q_next;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    quotient_d  = neg_q_q ? (~q_next + WIDTH'(1)) : q_next;
                    remainder_d = neg_r_q ? (~rem_next[WIDTH-1:0] + WIDTH'(1))
                                          : rem_next[WIDTH-1:0];
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    dbz_d       = 1'b0;
                    ovf_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
